// File: rtl/ps2_keyevent.sv
// PS/2 set-2 scancode sequence decoder: turns E0/F0-prefixed byte streams into
// {ext, break, code} events queued in a show-ahead FIFO, and tracks shift/ctrl.
module ps2_keyevent #(
    parameter int          DEPTH   = 4,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_byte_en,
    input  logic [7:0]               i_byte,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [7:0]               o_code,
    output logic                     o_ext,
    output logic                     o_break,
    output logic                     o_shift,
    output logic                     o_ctrl,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_tmo;
    logic              w_emit;
    logic              w_ev_ext;
    logic              w_ev_brk;
    logic              w_ignore;

    logic [9:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_ovf;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [9:0]        w_head;

    logic              r_lshift;
    logic              r_rshift;
    logic              r_lctrl;
    logic              r_rctrl;

    // Keyboard acks, BAT results, echo, resend and error bytes carry no key event
    assign w_ignore = i_byte inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_ev_ext    = 1'b0;
        w_ev_brk    = 1'b0;
        if (i_byte_en) begin
            case (r_state)
                IDLE: begin
                    if (i_byte == 8'hE0) begin
                        w_state_nxt = EXT;
                    end else if (i_byte == 8'hF0) begin
                        w_state_nxt = BRK;
                    end else if (!w_ignore) begin
                        w_emit = 1'b1;
                    end
                end
                EXT: begin
                    if (i_byte == 8'hF0) begin
                        w_state_nxt = EXT_BRK;
                    end else if (i_byte != 8'hE0) begin
                        w_emit      = 1'b1;
                        w_ev_ext    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                BRK: begin
                    w_emit      = 1'b1;
                    w_ev_brk    = 1'b1;
                    w_state_nxt = IDLE;
                end
                EXT_BRK: begin
                    w_emit      = 1'b1;
                    w_ev_ext    = 1'b1;
                    w_ev_brk    = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end else if (r_state != IDLE && r_tmo == TIMEOUT - 16'd1) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo <= '0;
        end else if (i_byte_en || r_state == IDLE || w_state_nxt == IDLE) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 16'd1;
        end
    end

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = (r_count != '0) && i_ready;
    assign w_push = w_emit && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_ev_ext, w_ev_brk, i_byte};
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_emit && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Modifiers track every decoded event, including ones the full FIFO dropped
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_lctrl  <= 1'b0;
            r_rctrl  <= 1'b0;
        end else if (w_emit) begin
            if (!w_ev_ext) begin
                if (i_byte == 8'h12) r_lshift <= !w_ev_brk;
                if (i_byte == 8'h59) r_rshift <= !w_ev_brk;
                if (i_byte == 8'h14) r_lctrl  <= !w_ev_brk;
            end else if (i_byte == 8'h14) begin
                r_rctrl <= !w_ev_brk;
            end
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign o_valid    = (r_count != '0);
    assign o_code     = o_valid ? w_head[7:0] : 8'h00;
    assign o_ext      = o_valid & w_head[9];
    assign o_break    = o_valid & w_head[8];
    assign o_shift    = r_lshift | r_rshift;
    assign o_ctrl     = r_lctrl | r_rctrl;
    assign o_count    = r_count;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_ps2_keyevent.sv
// Cycle-by-cycle vector bench for ps2_keyevent with DEPTH=4, TIMEOUT=8; timeout
// and asynchronous reset sequences are written out by hand after the table.
module tb_ps2_keyevent;

    logic       clk;
    logic       i_rst;
    logic       i_byte_en;
    logic [7:0] i_byte;
    logic       i_ready;
    logic       o_valid;
    logic [7:0] o_code;
    logic       o_ext;
    logic       o_break;
    logic       o_shift;
    logic       o_ctrl;
    logic [2:0] o_count;
    logic       o_overflow;

    ps2_keyevent #(
        .DEPTH   (4),
        .TIMEOUT (16'd8)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_byte_en  (i_byte_en),
        .i_byte     (i_byte),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_code     (o_code),
        .o_ext      (o_ext),
        .o_break    (o_break),
        .o_shift    (o_shift),
        .o_ctrl     (o_ctrl),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [7:0]  b;
        logic        rdy;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // {valid, code, ext, break, shift, ctrl, count, overflow}
    function automatic logic [16:0] mk(input logic vld, input logic [7:0] code, input logic ext,
                                       input logic brk, input logic sh, input logic ct,
                                       input logic [2:0] cnt, input logic ovf);
        return {vld, code, ext, brk, sh, ct, cnt, ovf};
    endfunction

    task automatic v(input logic en, input logic [7:0] b, input logic rdy, input logic [16:0] e);
        vec_t t;
        t.en  = en;
        t.b   = b;
        t.rdy = rdy;
        t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [16:0] e);
        logic [16:0] act;
        act = {o_valid, o_code, o_ext, o_break, o_shift, o_ctrl, o_count, o_overflow};
        n_checks++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s got %b want %b (vld,code,ext,brk,sh,ct,cnt,ovf)", name, act, e);
        end
    endtask

    task automatic cyc(input logic en, input logic [7:0] b, input logic rdy);
        i_byte_en = en;
        i_byte    = b;
        i_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [16:0] z;
        z = '0;
        // Make then break of 1C with consumer ready
        v(1, 8'h1C, 1, mk(1, 8'h1C, 0, 0, 0, 0, 1, 0));
        v(1, 8'hF0, 1, z);
        v(1, 8'h1C, 1, mk(1, 8'h1C, 0, 1, 0, 0, 1, 0));
        v(0, 8'h00, 1, z);
        // Extended make/break queued with consumer stalled
        v(1, 8'hE0, 0, z);
        v(1, 8'h75, 0, mk(1, 8'h75, 1, 0, 0, 0, 1, 0));
        v(1, 8'hE0, 0, mk(1, 8'h75, 1, 0, 0, 0, 1, 0));
        v(1, 8'hF0, 0, mk(1, 8'h75, 1, 0, 0, 0, 1, 0));
        v(1, 8'h75, 0, mk(1, 8'h75, 1, 0, 0, 0, 2, 0));
        v(0, 8'h00, 1, mk(1, 8'h75, 1, 1, 0, 0, 1, 0));
        v(0, 8'h00, 1, z);
        // Shift and ctrl tracking, fake shift ignored
        v(1, 8'h12, 1, mk(1, 8'h12, 0, 0, 1, 0, 1, 0));
        v(1, 8'h1C, 1, mk(1, 8'h1C, 0, 0, 1, 0, 1, 0));
        v(1, 8'hF0, 1, mk(0, 8'h00, 0, 0, 1, 0, 0, 0));
        v(1, 8'h12, 1, mk(1, 8'h12, 0, 1, 0, 0, 1, 0));
        v(1, 8'hE0, 1, z);
        v(1, 8'h12, 1, mk(1, 8'h12, 1, 0, 0, 0, 1, 0));
        v(1, 8'hE0, 1, z);
        v(1, 8'h14, 1, mk(1, 8'h14, 1, 0, 0, 1, 1, 0));
        v(0, 8'h00, 1, mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
        v(1, 8'hE0, 0, mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
        v(1, 8'hF0, 0, mk(0, 8'h00, 0, 0, 0, 1, 0, 0));
        v(1, 8'h14, 0, mk(1, 8'h14, 1, 1, 0, 0, 1, 0));
        v(0, 8'h00, 1, z);
        // Fill, overflow on a dropped shift make, then push+pop while full
        v(1, 8'h15, 0, mk(1, 8'h15, 0, 0, 0, 0, 1, 0));
        v(1, 8'h16, 0, mk(1, 8'h15, 0, 0, 0, 0, 2, 0));
        v(1, 8'h1D, 0, mk(1, 8'h15, 0, 0, 0, 0, 3, 0));
        v(1, 8'h24, 0, mk(1, 8'h15, 0, 0, 0, 0, 4, 0));
        v(1, 8'h12, 0, mk(1, 8'h15, 0, 0, 1, 0, 4, 1));
        v(1, 8'h2D, 1, mk(1, 8'h16, 0, 0, 1, 0, 4, 1));
        v(0, 8'h00, 1, mk(1, 8'h1D, 0, 0, 1, 0, 3, 1));
        v(0, 8'h00, 1, mk(1, 8'h24, 0, 0, 1, 0, 2, 1));
        v(0, 8'h00, 1, mk(1, 8'h2D, 0, 0, 1, 0, 1, 1));
        v(0, 8'h00, 1, mk(0, 8'h00, 0, 0, 1, 0, 0, 1));
        v(0, 8'h00, 1, mk(0, 8'h00, 0, 0, 1, 0, 0, 1));
        v(1, 8'hF0, 0, mk(0, 8'h00, 0, 0, 1, 0, 0, 1));
        v(1, 8'h12, 0, mk(1, 8'h12, 0, 1, 0, 0, 1, 1));
        v(0, 8'h00, 1, mk(0, 8'h00, 0, 0, 0, 0, 0, 1));
        // Ignored bytes, break of E0 taken literally, right shift
        v(1, 8'hFA, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1));
        v(1, 8'hAA, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1));
        v(1, 8'hF0, 0, mk(0, 8'h00, 0, 0, 0, 0, 0, 1));
        v(1, 8'hE0, 0, mk(1, 8'hE0, 0, 1, 0, 0, 1, 1));
        v(0, 8'h00, 1, mk(0, 8'h00, 0, 0, 0, 0, 0, 1));
        v(1, 8'h59, 0, mk(1, 8'h59, 0, 0, 1, 0, 1, 1));
        v(0, 8'h00, 1, mk(0, 8'h00, 0, 0, 1, 0, 0, 1));
        v(1, 8'hF0, 0, mk(0, 8'h00, 0, 0, 1, 0, 0, 1));
        v(1, 8'h59, 0, mk(1, 8'h59, 0, 1, 0, 0, 1, 1));
        v(0, 8'h00, 1, mk(0, 8'h00, 0, 0, 0, 0, 0, 1));

        i_rst     = 1'b1;
        i_byte_en = 1'b0;
        i_byte    = 8'h00;
        i_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", z);
        i_rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].en, vecs[i].b, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Eight idle clocks after E0 abandon the prefix
        cyc(1, 8'hE0, 0);
        repeat (8) cyc(0, 8'h00, 0);
        cyc(1, 8'h1C, 0);
        check("tmo_expired", mk(1, 8'h1C, 0, 0, 0, 0, 1, 1));
        cyc(0, 8'h00, 1);
        // Seven idle clocks keep it
        cyc(1, 8'hE0, 0);
        repeat (7) cyc(0, 8'h00, 0);
        cyc(1, 8'h1C, 0);
        check("tmo_kept", mk(1, 8'h1C, 1, 0, 0, 0, 1, 1));
        cyc(0, 8'h00, 1);
        check("tmo_drain", mk(0, 8'h00, 0, 0, 0, 0, 0, 1));

        // Asynchronous reset mid-sequence, between clock edges
        cyc(1, 8'h12, 0);
        cyc(1, 8'hF0, 0);
        check("pre_rst", mk(1, 8'h12, 0, 0, 1, 0, 1, 1));
        i_byte_en = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("async_rst", z);
        @(posedge clk);
        #1 i_rst = 1'b0;
        cyc(1, 8'h1C, 0);
        check("post_rst", mk(1, 8'h1C, 0, 0, 0, 0, 1, 0));
        cyc(0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_keyevent.md
PS2_KEYEVENT -- requirements
Module: ps2_keyevent

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 16'd50000, idle clocks before an incomplete sequence is discarded (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_byte_en  input  1  one-cycle strobe: i_byte holds a received scancode byte.
REQ-006 i_byte  input  8  received byte; sampled only when i_byte_en=1.
REQ-007 i_ready  input  1  consumer pops the head event when o_valid=1 and i_ready=1.
REQ-008 o_valid  output  1  FIFO non-empty.
REQ-009 o_code  output  8  head event scancode (show-ahead).
REQ-010 o_ext  output  1  head event was E0-prefixed.
REQ-011 o_break  output  1  head event is a release (F0-prefixed).
REQ-012 o_shift  output  1  live: left (12h) or right (59h) shift held, non-extended codes only.
REQ-013 o_ctrl  output  1  live: left (14h) or right (E0 14h) ctrl held.
REQ-014 o_count  output  $clog2(DEPTH)+1  events in FIFO.
REQ-015 o_overflow  output  1  sticky: an event was dropped on a full FIFO.

Function
REQ-016 Decoder FSM SHALL have states IDLE, EXT, BRK, EXT_BRK; it advances only on cycles with i_byte_en=1.
REQ-017 IDLE: E0h->EXT; F0h->BRK; FAh/AAh/EEh/FEh/00h/FFh ignored, stay IDLE; other byte b: emit {ext=0,brk=0,b}, stay IDLE.
REQ-018 EXT: F0h->EXT_BRK; E0h stays EXT; other b: emit {ext=1,brk=0,b}, ->IDLE.
REQ-019 BRK: any b, including E0h/F0h: emit {ext=0,brk=1,b}, ->IDLE.
REQ-020 EXT_BRK: any b: emit {ext=1,brk=1,b}, ->IDLE.
REQ-021 Timeout counter SHALL clear on every i_byte_en and in IDLE; in a non-IDLE state after TIMEOUT consecutive clocks without i_byte_en, FSM SHALL return to IDLE with nothing emitted.
REQ-022 An emitted event SHALL be written to the FIFO on the clock edge that consumes its final byte; o_valid rises the next cycle (1-cycle latency from final i_byte_en to o_valid on empty FIFO).
REQ-023 Pop SHALL occur when o_valid & i_ready; o_code/o_ext/o_break SHALL then show the next entry the following cycle.
REQ-024 Push with FIFO full and no pop: event dropped, o_overflow set, stays 1 until reset.
REQ-025 Push and pop same cycle: both SHALL take effect, o_count unchanged, including when full (no drop, no overflow).
REQ-026 Pop with FIFO empty: no effect. Pointers wrap modulo DEPTH.
REQ-027 Modifier registers (lshift, rshift, lctrl, rctrl) SHALL update on every emitted event even if dropped: make sets, break clears; o_shift/o_ctrl change the cycle after the final byte.
REQ-028 o_shift SHALL ignore E0 12h/E0 59h (fake shifts).

Reset
REQ-029 While i_rst=1, asynchronously: FSM=IDLE, timeout counter=0, FIFO empty (o_valid=0, o_count=0), o_code=00h, o_ext=0, o_break=0, o_shift=0, o_ctrl=0, o_overflow=0.
REQ-030 Reset mid-sequence (e.g. after E0h) SHALL discard the partial sequence; first post-reset byte is decoded from IDLE.

Verification
REQ-031 Bytes 1Ch, F0h, 1Ch, i_ready=1 -> events {0,0,1Ch} then {0,1,1Ch}; o_valid 1 cycle after each final byte.
REQ-032 Bytes E0h, 75h, E0h, F0h, 75h -> events {1,0,75h}, {1,1,75h}; o_count=2 with i_ready=0.
REQ-033 Bytes 12h, 1Ch, F0h, 12h -> o_shift=1 after first byte, 0 after F0h 12h; E0h 12h leaves o_shift=0; E0h 14h sets o_ctrl=1.
REQ-034 DEPTH=4, i_ready=0, five make codes -> o_count=4, o_overflow=1, head=first code; with full FIFO, push+pop same cycle -> o_count=4, no further drop.
REQ-035 TIMEOUT=8: E0h then 8 idle clocks, then 1Ch -> event {0,0,1Ch}; 7 idle clocks then 1Ch -> {1,0,1Ch}.
REQ-036 Bytes FAh, AAh in IDLE -> no event; assert i_rst after F0h, release, send 1Ch -> {0,0,1Ch}.
